// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and default parameters for the UART receiver.
`default_nettype none

package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer that resets to 1 so an idle or undriven line never looks like a start bit.
`default_nettype none

module uart_rx_sync (
  input  logic rxclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge rxclk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1 UART receiver with framing/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
`default_nettype none

module uart_receiver
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 rxclk,
  input  logic                 rst,
  input  logic                 rxclken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rdy,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_next;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  logic                 s_mid;
  logic                 s_last;
  logic                 b_last;
  logic                 scnt_clr;
  logic                 shift_en;
  logic                 stop_en;
`ifdef UART_RX_PARITY_EN
  logic                 par_en;
  logic                 par_bit;
`endif

  uart_rx_sync u_sync (
    .rxclk (rxclk),
    .rst   (rst),
    .d     (rx),
    .q     (rx_s)
  );

  assign s_mid  = (scnt == S_MID);
  assign s_last = (scnt == S_LAST);
  assign b_last = (bcnt == B_LAST);

  always_ff @(posedge rxclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (rxclken) begin
      case (state)
        IDLE:   if (!rx_s) state_next = START;
        START:  if (s_mid) state_next = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        DATA:   if (s_last && b_last) state_next = PARITY;
`else
        DATA:   if (s_last && b_last) state_next = STOP;
`endif
        PARITY: if (s_last) state_next = STOP;
        STOP:   if (s_last) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Strobes are already qualified by rxclken; scnt_clr is applied only on ticks.
  always_comb begin
    scnt_clr = 1'b1;
    shift_en = 1'b0;
    stop_en  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
`endif
    case (state)
      START: scnt_clr = s_mid;
      DATA: begin
        scnt_clr = s_last;
        shift_en = rxclken && s_last;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        scnt_clr = s_last;
        par_en   = rxclken && s_last;
      end
`endif
      STOP: begin
        scnt_clr = s_last;
        stop_en  = rxclken && s_last;
      end
      default: scnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge rxclk) begin
    if (rst) begin
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      dout      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      if (rxclken) begin
        scnt <= scnt_clr ? '0 : scnt + 1'b1;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        bcnt  <= b_last ? '0 : bcnt + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (par_en) begin
        par_bit <= rx_s;
      end
`endif
      if (stop_en) begin
        frame_err <= !rx_s;
        if (rx_s) begin
          dout <= shreg;
`ifdef UART_RX_PARITY_EN
          parity_err <= (^shreg) ^ par_bit;
`endif
        end
      end
      // A completing frame takes priority over a coincident clear.
      if (stop_en && rx_s) begin
        rdy     <= 1'b1;
        overrun <= rdy;
      end else if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with a scoreboard queue checked by an independent output monitor.
`default_nettype none

module tb_uart_receiver;

  localparam int OS = 16;

  logic       rxclk = 1'b0;
  logic       rst = 1'b1;
  logic       rxclken = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] dout;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       bad_par = 1'b0;
`endif
  logic       tick_en = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [10:0] q[$];   // {dout, rdy, overrun, frame_err}

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .rxclk     (rxclk),
    .rst       (rst),
    .rxclken   (rxclken),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .dout      (dout),
    .rdy       (rdy),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 rxclk = ~rxclk;

  // Oversample tick every second clock, gated by tick_en for stall tests.
  initial begin
    logic phase;
    phase = 1'b0;
    forever begin
      @(negedge rxclk);
      rxclken = tick_en && phase;
      phase = ~phase;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge rxclk); while (!rxclken);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int stall_bit);
    #1 rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      if (i == stall_bit) begin
        wait_ticks(OS / 2);
        tick_en = 1'b0;
        repeat (40) @(posedge rxclk);
        tick_en = 1'b1;
        wait_ticks(OS / 2);
      end else begin
        wait_ticks(OS);
      end
    end
`ifdef UART_RX_PARITY_EN
    #1 rx = (^d) ^ bad_par;
    wait_ticks(OS);
`endif
    if (stop_ok) begin
      #1 rx = 1'b1;
      wait_ticks(OS);
    end else begin
      // Short low stop bit so the trailing line rise is seen as a false start.
      #1 rx = 1'b0;
      wait_ticks(OS / 2 + 4);
      #1 rx = 1'b1;
    end
    wait_ticks(OS);
  endtask

  task automatic pulse_clr();
    @(negedge rxclk) rdy_clr = 1'b1;
    @(negedge rxclk) rdy_clr = 1'b0;
  endtask

  // Monitor: any new rdy, overrun or frame_err assertion is an output event.
  initial begin
    logic [10:0] cur, exp;
    logic p_rdy, p_ov, p_fe;
    p_rdy = 1'b0; p_ov = 1'b0; p_fe = 1'b0;
    forever begin
      @(negedge rxclk);
      cur = {dout, rdy, overrun, frame_err};
      if (!rst && ((rdy && !p_rdy) || (overrun && !p_ov) || (frame_err && !p_fe))) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", cur);
        end else begin
          exp = q.pop_front();
          checks++;
          if (cur !== exp) begin
            errors++;
            $display("FAIL event {dout,rdy,ovr,ferr}: got %0h expected %0h", cur, exp);
          end
        end
      end
      p_rdy = rdy; p_ov = overrun; p_fe = frame_err;
    end
  end

  initial begin
    repeat (4) @(posedge rxclk);
    @(negedge rxclk);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    repeat (100) @(posedge rxclk);
    @(negedge rxclk);
    check("idle_rdy", 32'(rdy), 32'h0);

    q.push_back({8'h35, 1'b1, 1'b0, 1'b0});
    send_frame(8'h35, 1'b1, -1);
    pulse_clr();
    check("clr_rdy", 32'(rdy), 32'h0);

    // False start: line low for only 3 ticks.
    #1 rx = 1'b0;
    wait_ticks(3);
    #1 rx = 1'b1;
    wait_ticks(2 * OS);
    check("false_start_rdy", 32'(rdy), 32'h0);
    check("false_start_dout", 32'(dout), 32'h35);

    q.push_back({8'h35, 1'b0, 1'b0, 1'b1});
    send_frame(8'hA5, 1'b0, -1);

    q.push_back({8'h35, 1'b1, 1'b0, 1'b0});
    send_frame(8'h35, 1'b1, -1);
    q.push_back({8'hC3, 1'b1, 1'b1, 1'b0});
    send_frame(8'hC3, 1'b1, -1);
    pulse_clr();
    check("ovr_clr_rdy", 32'(rdy), 32'h0);
    check("ovr_clr_overrun", 32'(overrun), 32'h0);

    // rdy_clr held across the completing edge: the set must still win.
    @(negedge rxclk) rdy_clr = 1'b1;
    q.push_back({8'h7E, 1'b1, 1'b0, 1'b0});
    send_frame(8'h7E, 1'b1, -1);
    @(negedge rxclk) rdy_clr = 1'b0;

    // Abort 0x5A mid-DATA with reset.
    #1 rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      #1 rx = i[0];
      wait_ticks(OS);
    end
    @(negedge rxclk);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge rxclk);
    check("midrst_dout", 32'(dout), 32'h00);
    check("midrst_rdy", 32'(rdy), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    wait_ticks(OS);

    q.push_back({8'h12, 1'b1, 1'b0, 1'b0});
    send_frame(8'h12, 1'b1, 3);
`ifdef UART_RX_PARITY_EN
    check("good_parity_err", 32'(parity_err), 32'h0);
    pulse_clr();
    bad_par = 1'b1;
    q.push_back({8'h0F, 1'b1, 1'b0, 1'b0});
    send_frame(8'h0F, 1'b1, -1);
    bad_par = 1'b0;
    check("bad_parity_err", 32'(parity_err), 32'h1);
`endif

    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge rxclk);
    check("events_pending", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Asynchronous serial (UART, 8N1) receiver: start bit, 8 data bits LSB-first, one stop bit.
- Sits behind an external baud generator that supplies a one-cycle oversampling tick (rxclken) in the rxclk domain.
- Recovers each byte on dout, flags it with rdy, and reports framing and overrun errors.

Parameters:
- OVERSAMPLE, 16, rxclken ticks per bit period; even, >= 4.
- DATA_BITS, 8, data bits per frame; dout width.

Ports:
- rxclk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rxclken  input  1  oversample tick; the state machine advances only on rxclk edges where rxclken=1.
- rx  input  1  asynchronous serial line, idle high.
- rdy_clr  input  1  one-cycle pulse that clears rdy.
- dout  output  DATA_BITS  last correctly received byte.
- rdy  output  1  new byte available (sticky until cleared).
- frame_err  output  1  last frame had stop bit = 0.
- overrun  output  1  a byte completed while rdy was still 1.

Behaviour:
- One clock (rxclk); reset is synchronous and active-high (rst).
- Reset values: dout=0, rdy=0, frame_err=0, overrun=0, state=IDLE, counters=0, synchronizer flops=1 (idle line).
- rx passes through a 2-flop synchronizer; every reference to rx below means the synchronized value (2 rxclk cycles of latency).
- Unknown or undriven rx before the first transition must not start a frame: the synchronizer resets to 1.
- Sample counter scnt counts rxclken ticks. Bit counter bcnt runs 0..DATA_BITS-1.
- IDLE: on a tick with rx=0, go to START with scnt=0.
- START: on the tick where scnt reaches OVERSAMPLE/2-1 (mid start bit), resample rx.
  - rx=1: false start; return to IDLE with no output change.
  - rx=0: go to DATA with scnt=0, bcnt=0.
- DATA: every OVERSAMPLE ticks (scnt==OVERSAMPLE-1), shift rx into the shift register MSB-side, so the first bit received ends up in dout[0].
  - After bit DATA_BITS-1, go to STOP.
- STOP: after OVERSAMPLE ticks, sample rx.
  - rx=1: dout<=shift register, rdy<=1, frame_err<=0, overrun<=rdy (old value).
  - rx=0: frame_err<=1; dout, rdy and overrun unchanged.
  - Either way, return to IDLE. A new start bit can be detected on the next tick.
- Outputs are registered. rdy/dout update on the rxclk edge of the stop-sample tick.
- rdy_clr=1 clears rdy and overrun on the next edge. If set and clear coincide, set wins.
- rxclken=0: state and counters hold; rdy_clr is still honoured.
- rst during a frame: abort immediately, back to IDLE with reset values.
- Counter widths: $clog2(OVERSAMPLE) and $clog2(DATA_BITS). No wrap beyond terminal counts.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit at its mid-point.
  - Extra output parity_err (1 bit, reset 0) is set when the XOR of the data bits and the parity bit is 1, and is cleared on the next good frame.
  - dout and rdy still update if the stop bit is valid.
- Undefined: no PARITY state and no parity_err port; 8N1 only.

Decomposition:
- Package uart_rx_pkg: enum rx_state_t {IDLE, START, DATA, PARITY, STOP}, localparam defaults OVERSAMPLE_DEF=16, DATA_BITS_DEF=8.
- One sub-module: uart_rx_sync (2-flop synchronizer with reset value 1), instantiated on rx.

Test Plan:
- Reset with rx=1, rxclken=1 -> dout=0x00, rdy=0, frame_err=0, overrun=0; stays IDLE for 100 cycles.
- Frame start=0, bits 1,0,1,0,1,1,0,0 (LSB first), stop=1, bit period OVERSAMPLE ticks -> dout=0x35, rdy=1, frame_err=0; pulse rdy_clr -> rdy=0 next edge.
- rx low for only 3 ticks then high -> false start; returns to IDLE, rdy stays 0, dout unchanged.
- Send 0xA5 with stop bit=0 -> frame_err=1, rdy=0, dout holds the previous value (0x35).
- Send 0x35 then 0xC3 without rdy_clr -> dout=0xC3, rdy=1, overrun=1; rdy_clr on the same edge as the second completion -> rdy stays 1.
- Assert rst mid-DATA of 0x5A, then send 0x12 -> dout=0x12, no residue from the aborted frame. With UART_RX_PARITY_EN, a bad parity bit -> parity_err=1.
